// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART0 TX two-requester arbiter.
package uart_arb_pkg;

    // Arbiter ownership states: nobody, core MMIO path, debug console path.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    // ASCII line feed, the default end-of-message byte.
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // One-hot owner encoding presented on the grant port.
    function automatic logic [1:0] grant_onehot(input arb_state_t s);
        logic [1:0] g;
        g = 2'b00;
        case (s)
            GRANT0:  g = 2'b01;
            GRANT1:  g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of the UART0 TX FIFO write port.
// A requester owns the port for a whole message (until it sends EOM_CHAR)
// or until it sits idle for TIMEOUT_CYCLES cycles, at which point the grant
// is revoked and a one-cycle timeout_evt pulse is raised. Ties out of IDLE
// go to the requester that was not served last. The data path from the
// owner to the FIFO is purely combinational.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  EOM_CHAR       = ASCII_LF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       timeout_evt
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_last;        // 1 = requester 1 was served last
    logic             w_last_nxt;
    logic [CNT_W-1:0] r_cnt;         // idle cycles while a grant is held
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;
    logic             w_xfer;
    logic             w_is_eom;

    // Route the owner's handshake straight to the FIFO; everything idles at 0.
    always_comb begin
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (r_state)
            GRANT0: begin
                tx_valid   = req0_valid;
                tx_data    = req0_data;
                req0_ready = tx_ready;
            end
            GRANT1: begin
                tx_valid   = req1_valid;
                tx_data    = req1_data;
                req1_ready = tx_ready;
            end
            default: ;
        endcase
    end

    assign w_xfer      = tx_valid & tx_ready;
    assign w_is_eom    = (tx_data == EOM_CHAR);
    assign grant       = grant_onehot(r_state);
    assign timeout_evt = r_timeout;

    // Next-state: arbitration from IDLE, release on EOM, revoke on idle timeout.
    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                // Counter is held at zero so every new grant starts fresh.
                w_cnt_nxt = '0;
                if (req0_valid && (!req1_valid || r_last)) begin
                    w_state_nxt = GRANT0;
                end else if (req1_valid) begin
                    w_state_nxt = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (w_xfer) begin
                    // A completed EOM transfer beats a coincident timeout.
                    w_cnt_nxt = '0;
                    if (w_is_eom) begin
                        w_state_nxt = IDLE;
                        w_last_nxt  = (r_state == GRANT1);
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = IDLE;
                    w_last_nxt    = (r_state == GRANT1);
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = 1'b1;
                end else if (~&r_cnt) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Control registers; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with TIMEOUT_CYCLES=16
// and one with TIMEOUT_CYCLES=4 share the same stimulus.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r0v, r1v, txr;
    logic [7:0] r0d, r1d;

    logic       ua_r0rdy, ua_r1rdy, ua_txv, ua_evt;
    logic [7:0] ua_txd;
    logic [1:0] ua_grant;
    logic       ub_r0rdy, ub_r1rdy, ub_txv, ub_evt;
    logic [7:0] ub_txd;
    logic [1:0] ub_grant;

    logic       sel;
    logic       m_r0rdy, m_r1rdy, m_txv, m_evt;
    logic [7:0] m_txd;
    logic [1:0] m_grant;

    logic [7:0] m0[$];
    logic [7:0] m1[$];
    logic       rdy_plan[$];
    logic [7:0] obs[$];
    logic [1:0] glog[$];
    logic       evlog[$];
    int         i0, i1, cyc;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(16), .EOM_CHAR(8'h0A)) ua (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_data(r0d), .req0_ready(ua_r0rdy),
        .req1_valid(r1v), .req1_data(r1d), .req1_ready(ua_r1rdy),
        .tx_valid(ua_txv), .tx_data(ua_txd), .tx_ready(txr),
        .grant(ua_grant), .timeout_evt(ua_evt)
    );

    uart_tx_arbiter #(.TIMEOUT_CYCLES(4), .EOM_CHAR(8'h0A)) ub (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_data(r0d), .req0_ready(ub_r0rdy),
        .req1_valid(r1v), .req1_data(r1d), .req1_ready(ub_r1rdy),
        .tx_valid(ub_txv), .tx_data(ub_txd), .tx_ready(txr),
        .grant(ub_grant), .timeout_evt(ub_evt)
    );

    assign m_r0rdy = sel ? ub_r0rdy : ua_r0rdy;
    assign m_r1rdy = sel ? ub_r1rdy : ua_r1rdy;
    assign m_txv   = sel ? ub_txv   : ua_txv;
    assign m_txd   = sel ? ub_txd   : ua_txd;
    assign m_grant = sel ? ub_grant : ua_grant;
    assign m_evt   = sel ? ub_evt   : ua_evt;

    // Reset both instances, clear the scenario state, release reset just after an edge.
    task automatic start_test(input logic s);
        sel   = s;
        rst_n = 1'b0;
        r0v = 1'b0; r0d = 8'h00; r1v = 1'b0; r1d = 8'h00; txr = 1'b1;
        m0.delete(); m1.delete(); rdy_plan.delete();
        obs.delete(); glog.delete(); evlog.delete();
        i0 = 0; i1 = 0; cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Present the next byte of each source message, record what the FIFO sees.
    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            bit acc0, acc1;
            r0v = (i0 < m0.size());
            r0d = 8'h00;
            if (r0v) r0d = m0[i0];
            r1v = (i1 < m1.size());
            r1d = 8'h00;
            if (r1v) r1d = m1[i1];
            txr = 1'b1;
            if (cyc < rdy_plan.size()) txr = rdy_plan[cyc];
            #1;
            if (m_txv && txr) obs.push_back(m_txd);
            glog.push_back(m_grant);
            evlog.push_back(m_evt);
            acc0 = r0v && m_r0rdy;
            acc1 = r1v && m_r1rdy;
            @(posedge clk);
            #1;
            if (acc0) i0++;
            if (acc1) i1++;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        r0v = 1'b1; r0d = 8'h41; r1v = 1'b1; r1d = 8'h78; txr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (ua_grant !== 2'b00) begin n_err++; $display("FAIL rst_grant: got %b expected 00", ua_grant); end
        n_vec++; if (ua_txv !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid: got %b expected 0", ua_txv); end
        n_vec++; if (ua_txd !== 8'h00) begin n_err++; $display("FAIL rst_tx_data: got %h expected 00", ua_txd); end
        n_vec++; if (ua_r0rdy !== 1'b0) begin n_err++; $display("FAIL rst_req0_ready: got %b expected 0", ua_r0rdy); end
        n_vec++; if (ua_r1rdy !== 1'b0) begin n_err++; $display("FAIL rst_req1_ready: got %b expected 0", ua_r1rdy); end
        n_vec++; if (ua_evt !== 1'b0) begin n_err++; $display("FAIL rst_timeout_evt: got %b expected 0", ua_evt); end
        n_vec++;
        if ({ub_grant, ub_txv, ub_txd, ub_r0rdy, ub_r1rdy, ub_evt} !== 14'h0000) begin
            n_err++;
            $display("FAIL rst_t4_outputs: got %h expected 0000", {ub_grant, ub_txv, ub_txd, ub_r0rdy, ub_r1rdy, ub_evt});
        end
    endtask

    task automatic test_two_messages();
        logic [7:0] eo[6] = '{8'h41, 8'h42, 8'h0A, 8'h78, 8'h79, 8'h0A};
        logic [1:0] eg[10] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        start_test(1'b0);
        m0 = '{8'h41, 8'h42, 8'h0A};
        m1 = '{8'h78, 8'h79, 8'h0A};
        run_cycles(10);
        n_vec++; if (obs.size() != 6) begin n_err++; $display("FAIL two_msg_count: got %0d expected 6", obs.size()); end
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if (k >= obs.size() || obs[k] !== eo[k]) begin
                n_err++; $display("FAIL two_msg_byte[%0d]: got %h expected %h", k, (k < obs.size()) ? obs[k] : 8'hxx, eo[k]);
            end
        end
        for (int k = 0; k < 10; k++) begin
            n_vec++;
            if (glog[k] !== eg[k]) begin n_err++; $display("FAIL two_msg_grant[%0d]: got %b expected %b", k, glog[k], eg[k]); end
        end
    endtask

    task automatic test_hold_grant();
        logic [7:0] eo[4] = '{8'h41, 8'h0A, 8'h5A, 8'h0A};
        logic [1:0] eg[12] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                               2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
        start_test(1'b0);
        m0 = '{8'h41};
        m1 = '{8'h5A, 8'h0A};
        run_cycles(6);
        n_vec++;
        if (obs.size() != 1 || i1 != 0) begin
            n_err++; $display("FAIL hold_no_z: got %0d bytes, %0d from req1, expected 1 and 0", obs.size(), i1);
        end
        m0.push_back(8'h0A);
        run_cycles(6);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (k >= obs.size() || obs[k] !== eo[k]) begin
                n_err++; $display("FAIL hold_byte[%0d]: got %h expected %h", k, (k < obs.size()) ? obs[k] : 8'hxx, eo[k]);
            end
        end
        for (int k = 0; k < 12; k++) begin
            n_vec++;
            if (glog[k] !== eg[k]) begin n_err++; $display("FAIL hold_grant[%0d]: got %b expected %b", k, glog[k], eg[k]); end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] eo[3] = '{8'h41, 8'h51, 8'h0A};
        logic [1:0] eg[10] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        logic       ee[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        start_test(1'b1);
        m0 = '{8'h41};
        m1 = '{8'h51, 8'h0A};
        run_cycles(10);
        for (int k = 0; k < 10; k++) begin
            n_vec++;
            if (glog[k] !== eg[k]) begin n_err++; $display("FAIL tmo_grant[%0d]: got %b expected %b", k, glog[k], eg[k]); end
            n_vec++;
            if (evlog[k] !== ee[k]) begin n_err++; $display("FAIL tmo_evt[%0d]: got %b expected %b", k, evlog[k], ee[k]); end
        end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (k >= obs.size() || obs[k] !== eo[k]) begin
                n_err++; $display("FAIL tmo_byte[%0d]: got %h expected %h", k, (k < obs.size()) ? obs[k] : 8'hxx, eo[k]);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] eo[3] = '{8'h78, 8'h79, 8'h0A};
        start_test(1'b0);
        m1 = '{8'h78, 8'h79, 8'h0A};
        rdy_plan.push_back(1'b1);
        rdy_plan.push_back(1'b1);
        for (int k = 0; k < 10; k++) rdy_plan.push_back(1'b0);
        run_cycles(16);
        n_vec++; if (obs.size() != 3) begin n_err++; $display("FAIL stall_count: got %0d expected 3", obs.size()); end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (k >= obs.size() || obs[k] !== eo[k]) begin
                n_err++; $display("FAIL stall_byte[%0d]: got %h expected %h", k, (k < obs.size()) ? obs[k] : 8'hxx, eo[k]);
            end
        end
        for (int k = 0; k < 16; k++) begin
            n_vec++;
            if (evlog[k] !== 1'b0) begin n_err++; $display("FAIL stall_evt[%0d]: got %b expected 0", k, evlog[k]); end
            n_vec++;
            if (glog[k] !== ((k >= 1 && k <= 13) ? 2'b10 : 2'b00)) begin
                n_err++; $display("FAIL stall_grant[%0d]: got %b expected %b", k, glog[k], (k >= 1 && k <= 13) ? 2'b10 : 2'b00);
            end
        end
    endtask

    task automatic test_reset_mid_message();
        logic [7:0] eo[3] = '{8'h41, 8'h42, 8'h0A};
        logic [1:0] eg[4] = '{2'b00, 2'b01, 2'b00, 2'b00};
        start_test(1'b0);
        m0 = '{8'h41, 8'h42, 8'h0A};
        run_cycles(3);
        r0v = 1'b1; r0d = m0[i0];
        #1;
        n_vec++; if (ua_grant !== 2'b01) begin n_err++; $display("FAIL midrst_pre_grant: got %b expected 01", ua_grant); end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ua_grant, ua_txv, ua_txd, ua_r0rdy, ua_r1rdy, ua_evt} !== 14'h0000) begin
            n_err++; $display("FAIL midrst_outputs: got %h expected 0000", {ua_grant, ua_txv, ua_txd, ua_r0rdy, ua_r1rdy, ua_evt});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        glog.delete();
        run_cycles(4);
        n_vec++; if (obs.size() != 3) begin n_err++; $display("FAIL midrst_count: got %0d expected 3", obs.size()); end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (k >= obs.size() || obs[k] !== eo[k]) begin
                n_err++; $display("FAIL midrst_byte[%0d]: got %h expected %h", k, (k < obs.size()) ? obs[k] : 8'hxx, eo[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (glog[k] !== eg[k]) begin n_err++; $display("FAIL midrst_grant[%0d]: got %b expected %b", k, glog[k], eg[k]); end
        end
    endtask

    task automatic test_eom_on_threshold();
        logic [7:0] eo[5] = '{8'h41, 8'h0A, 8'h4B, 8'h0A, 8'h43};
        logic [1:0] eg[11] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                               2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
        start_test(1'b1);
        m0 = '{8'h41};
        run_cycles(5);
        m0.push_back(8'h0A);
        m0.push_back(8'h43);
        m1 = '{8'h4B, 8'h0A};
        run_cycles(6);
        for (int k = 0; k < 11; k++) begin
            n_vec++;
            if (glog[k] !== eg[k]) begin n_err++; $display("FAIL eomthr_grant[%0d]: got %b expected %b", k, glog[k], eg[k]); end
            n_vec++;
            if (evlog[k] !== 1'b0) begin n_err++; $display("FAIL eomthr_evt[%0d]: got %b expected 0", k, evlog[k]); end
        end
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (k >= obs.size() || obs[k] !== eo[k]) begin
                n_err++; $display("FAIL eomthr_byte[%0d]: got %h expected %h", k, (k < obs.size()) ? obs[k] : 8'hxx, eo[k]);
            end
        end
    endtask

    initial begin
        sel = 1'b0;
        rst_n = 1'b0;
        r0v = 1'b0; r0d = 8'h00; r1v = 1'b0; r1d = 8'h00; txr = 1'b1;
        i0 = 0; i1 = 0; cyc = 0;
        test_reset();
        test_two_messages();
        test_hold_grant();
        test_timeout();
        test_stall();
        test_reset_mid_message();
        test_eom_on_threshold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-002 Parameter: TIMEOUT_CYCLES, default 1024, idle cycles before a held grant is revoked; legal range 2..65535.
REQ-003 Parameter: EOM_CHAR, default 8'h0A, end-of-message byte that releases a grant.
REQ-004 Port: clk  input  1  core clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: req0_valid  input  1  requester 0 (core MMIO path) has a byte.
REQ-007 Port: req0_data  input  8  requester 0 byte.
REQ-008 Port: req0_ready  output  1  requester 0 byte accepted this cycle when high with req0_valid.
REQ-009 Port: req1_valid  input  1  requester 1 (debug console path) has a byte.
REQ-010 Port: req1_data  input  8  requester 1 byte.
REQ-011 Port: req1_ready  output  1  requester 1 byte accepted this cycle when high with req1_valid.
REQ-012 Port: tx_valid  output  1  byte offered to the UART0 TX FIFO write port.
REQ-013 Port: tx_data  output  8  byte to the UART0 TX FIFO.
REQ-014 Port: tx_ready  input  1  UART0 TX FIFO not full.
REQ-015 Port: grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-016 Port: timeout_evt  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-017 A transfer occurs on a rising clk edge with tx_valid and tx_ready both high.
REQ-018 States: IDLE, GRANT0, GRANT1; state, last_served and idle counter are registered.
REQ-019 IDLE: tx_valid=0, req0_ready=0, req1_ready=0; no transfer ever completes in IDLE.
REQ-020 IDLE->GRANTn on the next edge: when only reqn_valid is high, pick n; when both are high, pick the requester that is not last_served.
REQ-021 GRANTn: tx_valid=reqn_valid, tx_data=reqn_data, reqn_ready=tx_ready, and the other ready=0; this path is combinational, with zero added latency.
REQ-022 GRANTn holds across transfers until a transfer with reqn_data==EOM_CHAR, then IDLE on the next edge and last_served=n.
REQ-023 Idle counter: cleared on entering GRANTn and on every transfer; it increments on every GRANTn cycle without a transfer, and saturates.
REQ-024 When the counter reaches TIMEOUT_CYCLES-1 in GRANTn without a transfer: IDLE on the next edge, last_served=n, timeout_evt=1 for exactly that next cycle.
REQ-025 If the EOM transfer and the timeout threshold fall on the same cycle, the EOM rule wins and timeout_evt stays 0.
REQ-026 tx_ready low stalls the owner; stalled cycles count toward the timeout.
REQ-027 A withdrawn reqn_valid with no transfer is legal; the grant is kept until EOM or timeout.
REQ-028 Counter width is $clog2(TIMEOUT_CYCLES+1); tx_data equals 8'h00 in IDLE.

Reset
REQ-029 rst_n low forces, immediately: state=IDLE, last_served=1 (so requester 0 wins the first tie), counter=0, grant=0, tx_valid=0, tx_data=0, both readys=0, timeout_evt=0.
REQ-030 Reset in mid-message drops the grant with no partial transfer; after rst_n rises, arbitration restarts per REQ-020.

Structure
REQ-031 The shared package uart_arb_pkg holds the state enum arb_state_t {IDLE, GRANT0, GRANT1} and the constant ASCII_LF=8'h0A used as the EOM_CHAR default.
REQ-032 The block is a single module with the counter inline; no sub-module.

Verification
REQ-033 Both valid at reset release, req0 sends "AB\n", req1 sends "xy\n", tx_ready=1 -> tx stream "AB\nxy\n", grant 01 then 10, one IDLE cycle between messages.
REQ-034 req0 holds grant and sends "A", req1 valid with "Z" -> "Z" is not forwarded until req0 sends 0x0A.
REQ-035 TIMEOUT_CYCLES=4, req0 sends "A" then drops valid -> IDLE after 4 idle cycles, timeout_evt pulses once, req1 granted next.
REQ-036 tx_ready=0 for 10 cycles with TIMEOUT_CYCLES=16 during a req1 message -> no transfer, no timeout, message completes after tx_ready returns to 1.
REQ-037 rst_n asserted during GRANT0 after "AB" -> all outputs 0 immediately, no byte lost or duplicated beyond the handshake record.
REQ-038 TIMEOUT_CYCLES=4, EOM transfer on the threshold cycle -> IDLE, timeout_evt=0, last_served=0.
